// File: rtl/ram8_fifo_if.sv
// rtl/ram8_fifo_if.sv - producer/consumer handshake bundle for ram8_fifo
interface ram8_fifo_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   // Master drives words in and takes words out; the FIFO is the slave.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/ram8_fifo.sv
// rtl/ram8_fifo.sv - register-array FIFO with valid/ready handshake on both sides
module ram8_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   ram8_fifo_if.slave               bus,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic             push;
   logic             pop;

   // Status and handshake come only from registered count, so ready never
   // depends on out_ready and valid never depends on in_valid.
   assign full          = (count == FULL_CNT);
   assign empty         = (count == '0);
   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign bus.out_data  = mem[rp];

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   // Storage array: no reset needed, a flushed word is simply never read.
   always_ff @(posedge clk) begin
      if (push && !clear && !reset) begin
         mem[wp] <= bus.in_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at their AW-bit width.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (clear) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wp <= wp + 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_ram8_fifo.sv
// tb/tb_ram8_fifo.sv - scoreboard bench for ram8_fifo
module tb_ram8_fifo;
   localparam int WIDTH = 8;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic [3:0] count;
   logic       full;
   logic       empty;

   int errors = 0;
   int checks = 0;
   logic [WIDTH-1:0] sb [$];

   ram8_fifo_if #(.WIDTH(WIDTH)) bus ();

   ram8_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (bus.slave),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_status(input string tag);
      int n;
      n = sb.size();
      check({tag, "_count"}, 32'(count), 32'(n));
      check({tag, "_full"}, 32'(full), 32'(n == DEPTH));
      check({tag, "_empty"}, 32'(empty), 32'(n == 0));
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(n != DEPTH));
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(n != 0));
      if (n != 0) check({tag, "_head"}, 32'(bus.out_data), 32'(sb[0]));
   endtask

   // One clock cycle of stimulus; called just after a falling edge.
   task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                       input logic clr, input string tag);
      bit push_ok;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      clear         = clr;
      if (!clr && ordy && sb.size() > 0) check({tag, "_pop_data"}, 32'(bus.out_data), 32'(sb[0]));
      @(posedge clk);
      if (clr) begin
         sb.delete();
      end else begin
         push_ok = iv && (sb.size() < DEPTH);
         if (ordy && sb.size() > 0) void'(sb.pop_front());
         if (push_ok) sb.push_back(d);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      clear         = 1'b0;
      check_status(tag);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_status("reset");
      reset = 1'b0;

      // Single word through an idle FIFO.
      step(1'b1, 8'hA5, 1'b0, 1'b0, "single_push");
      check("single_data", 32'(bus.out_data), 32'h0000_00A5);
      check("single_count", 32'(count), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0, "single_pop");
      check("single_empty", 32'(empty), 32'd1);

      // Fill, attempt overflow, then drain in order.
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
      check("fill_full", 32'(full), 32'd1);
      check("fill_in_ready", 32'(bus.in_ready), 32'd0);
      step(1'b1, 8'hFF, 1'b0, 1'b0, "overflow");
      for (int i = 1; i <= 8; i++) begin
         check("drain_order", 32'(bus.out_data), 32'(i));
         step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      end

      // Hold three words and push/pop every cycle across the wrap.
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "pre3");
      for (int i = 3; i < 23; i++) begin
         check("wrap_head", 32'(bus.out_data), 32'(8'h10 + i - 3));
         step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, "wrap");
         check("wrap_count3", 32'(count), 32'd3);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");

      // Full, pop one, refill on the very next cycle.
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, "fill2");
      step(1'b0, 8'h00, 1'b1, 1'b0, "fullpop");
      check("fullpop_in_ready", 32'(bus.in_ready), 32'd1);
      step(1'b1, 8'h55, 1'b0, 1'b0, "refill");
      check("refill_count", 32'(count), 32'd8);
      for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
      check("last_is_55", 32'(bus.out_data), 32'h0000_0055);
      step(1'b0, 8'h00, 1'b1, 1'b0, "drain2_last");

      // Clear wins over a simultaneous push.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "pre5");
      step(1'b1, 8'h77, 1'b0, 1'b1, "clear");
      check("clear_count", 32'(count), 32'd0);
      check("clear_empty", 32'(empty), 32'd1);
      step(1'b1, 8'h88, 1'b0, 1'b0, "post_clear_push");
      check("post_clear_data", 32'(bus.out_data), 32'h0000_0088);
      step(1'b0, 8'h00, 1'b1, 1'b0, "post_clear_pop");

      // Asynchronous reset between edges.
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, "pre4");
      #2;
      reset = 1'b1;
      #1;
      check("areset_count", 32'(count), 32'd0);
      check("areset_empty", 32'(empty), 32'd1);
      check("areset_out_valid", 32'(bus.out_valid), 32'd0);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, 8'hC3, 1'b0, 1'b0, "first_after_reset");
      check("first_after_reset_count", 32'(count), 32'd1);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 49) == 0), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
